// File: rtl/prbs_pkg.sv
// Shared PRBS helpers: sequence-law step, popcount and the checker state type.
// Histories are carried at MAX_DEPTH bits with bit 0 = most recent stream bit.
package prbs_pkg;

   localparam int MAX_DEPTH = 32;
   localparam int MAX_WIDTH = 64;
   localparam int IDX_W     = 5;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_t;

   // Next stream bit implied by history h (h[k] = b[n-k]).
   function automatic logic prbs_bit(input logic [MAX_DEPTH-1:0] h,
                                     input logic [MAX_DEPTH-1:0] coeffs,
                                     input int depth);
      logic nb;
      nb = h[IDX_W'(depth - 1)];
      for (int i = 0; i < MAX_DEPTH; i++)
         if ((i < depth - 1) && coeffs[i])
            nb = nb ^ h[i];
      return nb;
   endfunction

   function automatic logic [MAX_DEPTH-1:0] prbs_step(input logic [MAX_DEPTH-1:0] h,
                                                      input logic [MAX_DEPTH-1:0] coeffs,
                                                      input int depth);
      return {h[MAX_DEPTH-2:0], prbs_bit(h, coeffs, depth)};
   endfunction

   function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < MAX_WIDTH; i++)
         c = c + 7'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/prbs_gen_chk_advance.sv
// Combinational Width-step unroll: each step emits h[0] then shifts in the next bit.
// beat[k] is the bit emitted by step k+1; h_out is the history after all Width steps.
module prbs_advance
   import prbs_pkg::*;
#(
   parameter int               Depth  = 7,
   parameter logic [Depth-1:0] Coeffs = Depth'(7'h60),
   parameter int               Width  = 8
) (
   input  logic [Depth-1:0] h_in,
   output logic [Width-1:0] beat,
   output logic [Depth-1:0] h_out
);

   always_comb begin
      logic [Depth-1:0] h;
      h    = h_in;
      beat = '0;
      for (int k = 0; k < Width; k++) begin
         beat[k] = h[0];
         h       = Depth'(prbs_step(MAX_DEPTH'(h), MAX_DEPTH'(Coeffs), Depth));
      end
      h_out = h;
   end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator (valid/ready source) and self-synchronising checker with error counting.
// Stream handshake: a beat moves when valid && ready; data is held while valid && !ready.
module prbs_gen_chk
   import prbs_pkg::*;
#(
   parameter int               Depth     = 7,
   parameter logic [Depth-1:0] Coeffs    = Depth'(7'h60),
   parameter int               Width     = 8,
   parameter int               LockBeats = 4,
   parameter int               LossBeats = 4,
   parameter int               CntWidth  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                gen_en,
   input  logic                seed_load,
   input  logic [Depth-1:0]    seed,
   input  logic                inject_err,
   output logic [Width-1:0]    tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   input  logic [Width-1:0]    rx_data,
   input  logic                rx_valid,
   input  logic                err_clear,
   output logic                chk_locked,
   output logic                beat_err,
   output logic [CntWidth-1:0] err_count,
   output chk_state_t          chk_state
);

   localparam int LockW = $clog2(LockBeats + 1);
   localparam int LossW = $clog2(LossBeats + 1);
   localparam int SumW  = CntWidth + 8;

   // ---------------- generator ----------------
   logic [Depth-1:0] gen_h, gen_h_next;
   logic [Width-1:0] gen_beat;
   logic             inj_pending;
   logic             tx_xfer;

   prbs_advance #(.Depth(Depth), .Coeffs(Coeffs), .Width(Width)) u_gen_adv (
      .h_in  (gen_h),
      .beat  (gen_beat),
      .h_out (gen_h_next)
   );

   // The inversion lives only on the output path; gen_h never sees it.
   assign tx_data = gen_beat ^ Width'(inj_pending);
   assign tx_xfer = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         gen_h       <= Depth'(1);
         tx_valid    <= 1'b0;
         inj_pending <= 1'b0;
      end else begin
         tx_valid <= gen_en;
         if (seed_load)
            gen_h <= (seed == '0) ? Depth'(1) : seed;
         else if (tx_xfer)
            gen_h <= gen_h_next;
         if (inject_err)
            inj_pending <= 1'b1;
         else if (tx_xfer)
            inj_pending <= 1'b0;
      end
   end

   // ---------------- checker ----------------
   chk_state_t        state;
   logic [Depth-1:0]  chk_h;
   logic [Depth-1:0]  h_search, h_locked, lock_seed, lock_end;
   logic [Width-1:0]  pred_search, pred_locked, rx_err;
   logic [6:0]        nerr;
   logic [LockW-1:0]  clean_cnt;
   logic [LossW-1:0]  bad_cnt;
   logic [SumW-1:0]   err_sum;
   logic [CntWidth-1:0] err_next;

   // SEARCH: every bit is predicted from the bits actually received before it.
   always_comb begin
      logic [Depth-1:0] w;
      w           = chk_h;
      pred_search = '0;
      for (int k = 0; k < Width; k++) begin
         pred_search[k] = prbs_bit(MAX_DEPTH'(w), MAX_DEPTH'(Coeffs), Depth);
         w              = {w[Depth-2:0], rx_data[k]};
      end
      h_search = w;
   end

   // LOCKED: free-run from the stored history, ignoring received bits.
   assign lock_seed = Depth'(prbs_step(MAX_DEPTH'(chk_h), MAX_DEPTH'(Coeffs), Depth));

   prbs_advance #(.Depth(Depth), .Coeffs(Coeffs), .Width(Width)) u_chk_adv (
      .h_in  (lock_seed),
      .beat  (pred_locked),
      .h_out (lock_end)
   );

   // lock_end is one step past the last predicted bit; step it back once.
   always_comb begin
      logic top;
      top = lock_end[0];
      for (int i = 0; i < Depth - 1; i++)
         if (Coeffs[i])
            top = top ^ lock_end[i+1];
      h_locked = {top, lock_end[Depth-1:1]};
   end

   assign rx_err   = rx_data ^ ((state == LOCKED) ? pred_locked : pred_search);
   assign nerr     = popcount(MAX_WIDTH'(rx_err));
   assign err_sum  = SumW'(err_count) + SumW'(nerr);
   assign err_next = (err_sum > SumW'({CntWidth{1'b1}})) ? {CntWidth{1'b1}}
                                                         : err_sum[CntWidth-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEARCH;
         chk_h     <= '0;
         clean_cnt <= '0;
         bad_cnt   <= '0;
         beat_err  <= 1'b0;
         err_count <= '0;
      end else begin
         beat_err <= rx_valid && (nerr != 7'd0);
         if (rx_valid) begin
            case (state)
               SEARCH: begin
                  chk_h <= h_search;
                  if (nerr == 7'd0) begin
                     if (clean_cnt == LockW'(LockBeats - 1)) begin
                        state     <= LOCKED;
                        clean_cnt <= '0;
                        bad_cnt   <= '0;
                     end else begin
                        clean_cnt <= clean_cnt + 1'b1;
                     end
                  end else begin
                     clean_cnt <= '0;
                  end
               end
               LOCKED: begin
                  chk_h <= h_locked;
                  if (nerr != 7'd0) begin
                     if (bad_cnt == LossW'(LossBeats - 1)) begin
                        state     <= SEARCH;
                        clean_cnt <= '0;
                        bad_cnt   <= '0;
                     end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                     end
                  end else begin
                     bad_cnt <= '0;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
         if (err_clear)
            err_count <= '0;
         else if (rx_valid && (state == LOCKED))
            err_count <= err_next;
      end
   end

   assign chk_locked = (state == LOCKED);
   assign chk_state  = state;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: PRBS7 byte stream, stall hold, loopback lock/loss,
// error injection and a 4-bit counter instance for saturation and clear priority.
module tb_prbs_gen_chk;
   import prbs_pkg::*;

   logic clk;
   logic reset;

   // main instance (default parameters)
   logic        gen_en, seed_load, inject_err, tx_valid, tx_ready;
   logic        rx_valid, err_clear, chk_locked, beat_err;
   logic [6:0]  seed;
   logic [7:0]  tx_data, rx_data, rnd_data;
   logic        rnd_en;
   logic [15:0] err_count;
   chk_state_t  chk_state;

   // small-counter instance
   logic        gen_en4, tx_valid4, tx_ready4, rx_valid4, err_clear4, chk_locked4, beat_err4, inv4;
   logic [7:0]  tx_data4, rx_data4;
   logic [3:0]  err_count4;
   chk_state_t  chk_state4;

   assign rx_data   = rnd_en ? rnd_data : tx_data;
   assign rx_valid  = tx_valid & tx_ready;
   assign rx_data4  = tx_data4 ^ {7'b0, inv4};
   assign rx_valid4 = tx_valid4 & tx_ready4;

   prbs_gen_chk dut (
      .clk(clk), .reset(reset), .gen_en(gen_en), .seed_load(seed_load), .seed(seed),
      .inject_err(inject_err), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .err_clear(err_clear), .chk_locked(chk_locked),
      .beat_err(beat_err), .err_count(err_count), .chk_state(chk_state)
   );

   prbs_gen_chk #(.CntWidth(4), .LossBeats(32)) dut4 (
      .clk(clk), .reset(reset), .gen_en(gen_en4), .seed_load(1'b0), .seed(7'd0),
      .inject_err(1'b0), .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
      .rx_data(rx_data4), .rx_valid(rx_valid4), .err_clear(err_clear4), .chk_locked(chk_locked4),
      .beat_err(beat_err4), .err_count(err_count4), .chk_state(chk_state4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int   n_assert = 0;
   int   n_fail   = 0;
   int   m;                 // index of the beat the main generator is presenting
   logic mb [0:1100];       // bit-serial PRBS7 reference stream
   logic [7:0] beats [0:253];

   function automatic logic [7:0] model_byte(input int j);
      logic [7:0] v;
      int base;
      base = 6 + 8 * (j % 127);
      for (int k = 0; k < 8; k++) v[k] = mb[base + k];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      if (tx_valid && tx_ready && !seed_load) m++;
      @(posedge clk);
      #1;
   endtask

   int lock_at, bad, nper, pulses, n, held_ok;
   logic [7:0] held;

   initial begin
      // reference: b6 = 1, b0..b5 = 0, b[i+1] = b[i-6] ^ b[i-5]
      for (int i = 0; i < 7; i++) mb[i] = (i == 6);
      for (int i = 6; i < 1100; i++) mb[i+1] = mb[i-6] ^ mb[i-5];

      reset = 1; gen_en = 0; seed_load = 0; seed = '0; inject_err = 0; tx_ready = 1;
      err_clear = 0; rnd_en = 0; rnd_data = '0;
      gen_en4 = 0; tx_ready4 = 1; err_clear4 = 0; inv4 = 0;
      m = 0;
      repeat (3) @(posedge clk);
      #1;

      chk("rst_tx_valid",  tx_valid, 0);
      chk("rst_locked",    chk_locked, 0);
      chk("rst_beat_err",  beat_err, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_state",     chk_state, SEARCH);
      chk("rst_tx_data",   tx_data, 8'hC1);

      reset = 0; gen_en = 1;
      step();
      chk("tx_valid_up", tx_valid, 1);

      lock_at = -1;
      for (int i = 0; i < 254; i++) begin
         beats[i] = tx_data;
         if (lock_at < 0 && chk_locked) lock_at = i;
         step();
      end
      chk("beat0", beats[0], 8'hC1);
      chk("beat1", beats[1], 8'h50);
      chk("beat2", beats[2], 8'h3C);
      bad = 0;
      for (int i = 0; i < 254; i++) if (beats[i] !== model_byte(i)) bad++;
      chk("seq_vs_model", bad, 0);
      chk("period_127", beats[127], beats[0]);
      nper = 0;
      for (int p = 1; p < 127; p++) begin
         n = 0;
         for (int i = 0; i < 127; i++) if (beats[i] !== beats[i+p]) n++;
         if (n == 0) nper++;
      end
      chk("no_short_period", nper, 0);
      chk("lock_latency", lock_at, 5);

      // soak
      bad = 0; pulses = 0; n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (tx_data !== model_byte(m)) bad++;
         step();
         if (beat_err) pulses++;
         if (!chk_locked) n++;
      end
      chk("soak_seq", bad, 0);
      chk("soak_beat_err", pulses, 0);
      chk("soak_lock_held", n, 0);
      chk("soak_err_count", err_count, 0);

      // stall
      tx_ready = 0;
      held = tx_data;
      held_ok = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (tx_data !== held) held_ok++;
      end
      chk("stall_hold", held_ok, 0);
      chk("stall_model", held, model_byte(m));
      tx_ready = 1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_data !== model_byte(m)) bad++;
         step();
      end
      chk("post_stall_seq", bad, 0);

      // single injected error while locked
      inject_err = 1;
      step();
      inject_err = 0;
      chk("inject_bit0", tx_data, model_byte(m) ^ 8'h01);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (beat_err) pulses++;
      end
      chk("inject_pulses", pulses, 1);
      chk("inject_count", err_count, 1);
      chk("inject_lock_held", chk_locked, 1);

      // corrupted stream: lock must survive 3 errored beats and drop on the 4th
      rnd_en = 1;
      for (int i = 0; i < 4; i++) begin
         rnd_data = model_byte(m) ^ 8'($urandom_range(1, 255));
         step();
         if (i == 2) chk("locked_after_3", chk_locked, 1);
      end
      chk("loss_after_4", chk_locked, 0);
      rnd_en = 0;
      n = 0;
      while (!chk_locked && n < 20) begin
         step();
         n++;
      end
      chk("relock_beats", n, 4);
      err_clear = 1;
      step();
      err_clear = 0;
      chk("err_clear", err_count, 0);

      // seed handling
      seed_load = 1; seed = 7'd0;
      step();
      seed_load = 0; m = 0;
      chk("seed_zero", tx_data, 8'hC1);
      step();
      chk("seed_zero_next", tx_data, 8'h50);
      seed_load = 1; seed = 7'h7F;
      step();
      seed_load = 0;
      chk("seed_7f", tx_data, 8'h81);

      // reset mid-stream
      repeat (3) step();
      reset = 1;
      step();
      chk("midrst_tx_valid",  tx_valid, 0);
      chk("midrst_locked",    chk_locked, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_tx_data",   tx_data, 8'hC1);
      reset = 0; gen_en = 0;

      // 4-bit counter: saturation and clear priority
      gen_en4 = 1;
      repeat (10) step();
      chk("sat_locked", chk_locked4, 1);
      inv4 = 1;
      repeat (10) step();
      chk("sat_count10", err_count4, 10);
      repeat (10) step();
      chk("sat_count15", err_count4, 15);
      chk("sat_lock_held", chk_locked4, 1);
      err_clear4 = 1;
      step();
      err_clear4 = 0;
      chk("clear_wins", err_count4, 0);
      step();
      chk("count_after_clear", err_count4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
